// File: rtl/life_grid_seq.sv
// life_grid_seq -- advances a toroidal ROWS x COLS Game-of-Life grid by a
// requested number of generations, reusing one life_8c cell evaluator that
// visits one cell per clock in row-major order.
//
// The current grid (cur) and next grid (nxt) are double-buffered registers.
// A run evaluates every cell of cur into nxt (EVAL), then copies nxt into
// cur in a single cycle (COMMIT), and repeats until the target is reached.
//
// Optional feature macro: LIFE_HALT_STABLE_EN
//   When defined, a run stops early after a generation in which no cell
//   changed, and 'stable' is raised. When undefined, 'stable' is tied 0.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   load_en    in   write load_data into cur[load_row] (IDLE only)
//   load_row   in   row address for load
//   load_data  in   row contents, bit c = column c
//   start      in   begin a run (IDLE only)
//   num_gens   in   generations to compute, latched at start
//   rd_row     in   readback row address
//   rd_data    out  combinational read of cur[rd_row]
//   busy       out  high in EVAL and COMMIT
//   done       out  one-cycle pulse at run end
//   gen_cnt    out  generations completed in current/last run
//   stable     out  run ended because the grid stopped changing

module life_8c (
  input  logic       self,
  input  logic [7:0] neighbors,
  output logic       out
);
  logic [3:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + 4'(neighbors[i]);
  end

  // Birth on exactly 3, survival on 2 or 3.
  assign out = (cnt == 4'd3) || (self && (cnt == 4'd2));
endmodule

module life_grid_seq #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int ROW_AW = 3,
  parameter int COL_AW = 3,
  parameter int GEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ROW_AW-1:0] load_row,
  input  logic [COLS-1:0]   load_data,
  input  logic              start,
  input  logic [GEN_W-1:0]  num_gens,
  input  logic [ROW_AW-1:0] rd_row,
  output logic [COLS-1:0]   rd_data,
  output logic              busy,
  output logic              done,
  output logic [GEN_W-1:0]  gen_cnt,
  output logic              stable
);
  localparam int CW = ROW_AW + COL_AW;
  localparam logic [CW-1:0] LAST_CELL = CW'(ROWS * COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_COMMIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cell_q, cell_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic [GEN_W-1:0]  target_q, target_d;
  logic [GEN_W-1:0]  gen_inc;

  logic [COLS-1:0]   cur_q [ROWS];
  logic [COLS-1:0]   nxt_q [ROWS];

  logic              load_we;
  logic              eval_we;
  logic              commit;

  // Cell coordinates and torus-wrapped neighbour coordinates. ROWS and COLS
  // are powers of two, so plain modular address arithmetic gives the wrap.
  logic [ROW_AW-1:0] r, rm, rp;
  logic [COL_AW-1:0] c, cm, cp;
  logic [7:0]        nbr;
  logic              self_bit;
  logic              life_out;

  assign r  = cell_q[CW-1:COL_AW];
  assign c  = cell_q[COL_AW-1:0];
  assign rm = r - ROW_AW'(1);
  assign rp = r + ROW_AW'(1);
  assign cm = c - COL_AW'(1);
  assign cp = c + COL_AW'(1);

  assign self_bit = cur_q[r][c];
  assign nbr[0]   = cur_q[rm][c];
  assign nbr[1]   = cur_q[rm][cp];
  assign nbr[2]   = cur_q[r][cp];
  assign nbr[3]   = cur_q[rp][cp];
  assign nbr[4]   = cur_q[rp][c];
  assign nbr[5]   = cur_q[rp][cm];
  assign nbr[6]   = cur_q[r][cm];
  assign nbr[7]   = cur_q[rm][cm];

  life_8c u_cell (
    .self      (self_bit),
    .neighbors (nbr),
    .out       (life_out)
  );

  assign gen_inc = gen_q + GEN_W'(1);

`ifdef LIFE_HALT_STABLE_EN
  logic changed_q, changed_d;
  logic stable_q, stable_d;
`endif

  always_comb begin
    state_d  = state_q;
    cell_d   = cell_q;
    gen_d    = gen_q;
    target_d = target_q;
    load_we  = 1'b0;
    eval_we  = 1'b0;
    commit   = 1'b0;
`ifdef LIFE_HALT_STABLE_EN
    changed_d = changed_q;
    stable_d  = stable_q;
`endif
    case (state_q)
      S_IDLE: begin
        load_we = load_en;
        if (start) begin
          // A zero-generation start is still an accepted start: it clears
          // the status outputs but skips straight to the done pulse.
          gen_d = '0;
`ifdef LIFE_HALT_STABLE_EN
          stable_d  = 1'b0;
          changed_d = 1'b0;
`endif
          if (num_gens != '0) begin
            target_d = num_gens;
            cell_d   = '0;
            state_d  = S_EVAL;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_EVAL: begin
        eval_we = 1'b1;
`ifdef LIFE_HALT_STABLE_EN
        changed_d = changed_q | (life_out != self_bit);
`endif
        if (cell_q == LAST_CELL) state_d = S_COMMIT;
        else                     cell_d  = cell_q + CW'(1);
      end
      S_COMMIT: begin
        commit = 1'b1;
        gen_d  = gen_inc;
        if (gen_inc == target_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_EVAL;
          cell_d  = '0;
        end
`ifdef LIFE_HALT_STABLE_EN
        changed_d = 1'b0;
        if (!changed_q) begin
          state_d  = S_DONE;
          stable_d = 1'b1;
        end
`endif
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cell_q   <= '0;
      gen_q    <= '0;
      target_q <= '0;
`ifdef LIFE_HALT_STABLE_EN
      changed_q <= 1'b0;
      stable_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cell_q   <= cell_d;
      gen_q    <= gen_d;
      target_q <= target_d;
`ifdef LIFE_HALT_STABLE_EN
      changed_q <= changed_d;
      stable_q  <= stable_d;
`endif
    end
  end

  // Grid storage. cur is only written by a host load in IDLE or by the
  // whole-grid copy at COMMIT, so it is constant across EVAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        cur_q[i] <= '0;
        nxt_q[i] <= '0;
      end
    end else begin
      if (load_we) cur_q[load_row] <= load_data;
      if (commit) begin
        for (int i = 0; i < ROWS; i++) cur_q[i] <= nxt_q[i];
      end
      if (eval_we) nxt_q[r][c] <= life_out;
    end
  end

  assign rd_data = cur_q[rd_row];
  assign busy    = (state_q == S_EVAL) || (state_q == S_COMMIT);
  assign done    = (state_q == S_DONE);
  assign gen_cnt = gen_q;
`ifdef LIFE_HALT_STABLE_EN
  assign stable  = stable_q;
`else
  assign stable  = 1'b0;
`endif

endmodule

// File: tb/tb_life_grid_seq.sv
module tb_life_grid_seq;
  localparam int ROWS = 8, COLS = 8, ROW_AW = 3, COL_AW = 3, GEN_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_en;
  logic [ROW_AW-1:0] load_row;
  logic [COLS-1:0]   load_data;
  logic              start;
  logic [GEN_W-1:0]  num_gens;
  logic [ROW_AW-1:0] rd_row;
  logic [COLS-1:0]   rd_data;
  logic              busy;
  logic              done;
  logic [GEN_W-1:0]  gen_cnt;
  logic              stable;

  life_grid_seq #(.ROWS(ROWS), .COLS(COLS), .ROW_AW(ROW_AW), .COL_AW(COL_AW), .GEN_W(GEN_W)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_row(load_row), .load_data(load_data),
    .start(start), .num_gens(num_gens), .rd_row(rd_row), .rd_data(rd_data),
    .busy(busy), .done(done), .gen_cnt(gen_cnt), .stable(stable)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] mg;        // bench copy of the current grid, bit r*8+c
  int          exp_q[$];  // scoreboard: cycle, gens, stable, then 8 rows

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [63:0] life_step(input logic [63:0] g);
    logic [63:0] o;
    int n;
    o = '0;
    for (int rr = 0; rr < 8; rr++)
      for (int cc = 0; cc < 8; cc++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0))
              n += int'(g[((rr + dr + 8) % 8) * 8 + ((cc + dc + 8) % 8)]);
        o[rr * 8 + cc] = (n == 3) || (g[rr * 8 + cc] && n == 2);
      end
    return o;
  endfunction

  task automatic load(input int row, input logic [7:0] data);
    @(negedge clk);
    load_en = 1'b1; load_row = ROW_AW'(row); load_data = data;
    mg[row * 8 +: 8] = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic clear_grid();
    for (int i = 0; i < 8; i++) load(i, 8'h00);
  endtask

  // Called right after a negedge: pulses reset inside the low phase and
  // checks that every output is cleared before any clock edge.
  task automatic reset_check(input string tag);
    #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_row = ROW_AW'(i);
      #1;
      if (i == 0) begin
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_gen"}, int'(gen_cnt), 0);
        chk({tag, "_stable"}, int'(stable), 0);
      end
      chk({tag, "_row"}, int'(rd_data), 0);
    end
    rst = 1'b0;
    mg = '0;
  endtask

  // Called right after a negedge while idle; pops 8 expected rows.
  task automatic read_grid(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_row = ROW_AW'(i);
      #1;
      chk({tag, "_row"}, int'(rd_data), exp_q.pop_front());
    end
  endtask

  // kind 0: plain run; 1: load/start injected mid-run; 2: reset at cycle 30;
  // 3: row 2 loaded in the same cycle as start.
  task automatic run(input int n, input int kind, input string tag);
    logic [63:0] g, prev;
    int gens, stb, k, busy_seen, done_seen, limit;
    if (kind == 3) mg[2 * 8 +: 8] = 8'b00000111;
    g = mg; gens = 0; stb = 0;
    for (int i = 0; i < n; i++) begin
      prev = g;
      g = life_step(g);
      gens++;
`ifdef LIFE_HALT_STABLE_EN
      if (g == prev) begin stb = 1; break; end
`endif
    end
    if (kind == 2) g = '0;
    exp_q.push_back((n == 0) ? 1 : gens * 65 + 1);
    exp_q.push_back(gens);
    exp_q.push_back(stb);
    for (int i = 0; i < 8; i++) exp_q.push_back(int'(g[i * 8 +: 8]));

    @(negedge clk);
    start = 1'b1; num_gens = GEN_W'(n);
    if (kind == 3) begin load_en = 1'b1; load_row = 3'd2; load_data = 8'b00000111; end
    k = 0; busy_seen = 0; done_seen = 0;
    limit = (kind == 2) ? 300 : n * 65 + 100;
    while (k < limit) begin
      @(negedge clk);
      k++;
      start = 1'b0; load_en = 1'b0;
      if (busy) busy_seen = 1;
      if (done) begin done_seen = 1; break; end
      if (kind == 1 && k == 10) begin
        load_en = 1'b1; load_row = 3'd0; load_data = 8'hFF; start = 1'b1; num_gens = 8'd5;
      end
      if (kind == 2 && k == 30) reset_check({tag, "_midrst"});
    end

    if (kind == 2) begin
      chk({tag, "_no_done"}, done_seen, 0);
      void'(exp_q.pop_front()); void'(exp_q.pop_front()); void'(exp_q.pop_front());
    end else begin
      chk({tag, "_done_cycle"}, k, exp_q.pop_front());
      chk({tag, "_gen_cnt"}, int'(gen_cnt), exp_q.pop_front());
      chk({tag, "_stable"}, int'(stable), exp_q.pop_front());
      chk({tag, "_busy_seen"}, busy_seen, (n == 0) ? 0 : 1);
      @(negedge clk);
      chk({tag, "_done_pulse_end"}, int'(done), 0);
    end
    read_grid(tag);
    mg = g;
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_row = '0; load_data = '0;
    start = 1'b0; num_gens = '0; rd_row = '0; mg = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset clears a loaded grid immediately
    load(5, 8'hAA);
    load(1, 8'h3C);
    @(negedge clk);
    reset_check("reset");

    // Blinker, one generation, then two generations from horizontal
    load(3, 8'b00011100);
    run(1, 0, "blinker1");
    rd_row = 3'd4; #1;
    chk("blinker1_row4_literal", int'(rd_data), 8'b00001000);
    load(2, 8'h00); load(4, 8'h00); load(3, 8'b00011100);
    run(2, 0, "blinker2");
    rd_row = 3'd3; #1;
    chk("blinker2_row3_literal", int'(rd_data), 8'b00011100);

    // Zero generations
    run(0, 0, "zero");

    // Glider across the torus, row 2 loaded together with start
    clear_grid();
    load(0, 8'b00000010);
    load(1, 8'b00000100);
    run(32, 3, "glider");
    rd_row = 3'd2; #1;
    chk("glider_row2_literal", int'(rd_data), 8'b00000111);

    // Still-life block
    clear_grid();
    load(1, 8'b00000110);
    load(2, 8'b00000110);
    run(10, 0, "block");

    // Load/start ignored while busy
    clear_grid();
    load(3, 8'b00011100);
    run(1, 1, "interfere");

    // Reset mid-run, then a normal run
    clear_grid();
    load(3, 8'b00011100);
    run(1, 2, "abort");
    load(3, 8'b00011100);
    run(1, 0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
